// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one registered output stage.
// MODE 0 rotates priority from the last accepted channel; MODE 1 is fixed
// priority with channel 0 highest.
module rr_arb_mux #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel
);

    logic [SW-1:0]    last;
    logic [SW-1:0]    start;
    logic [SW-1:0]    win;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] sel_data;
    logic             can_load;
    logic             load;
    int unsigned      idx;

    assign can_load = ~out_valid | out_ready;
    assign in_ready = (reset || !can_load) ? '0 : grant;
    assign load     = |(in_valid & in_ready);

    // Fixed priority reuses the rotating scan with the start pinned at N-1,
    // so the scan always begins at channel 0.
    assign start = (MODE == 1) ? SW'(N - 1) : last;

    // Scan start+1, start+2, ... modulo N; first requester found wins.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(start) + k) % N;
            if (grant == '0 && in_valid[idx[SW-1:0]]) begin
                grant[idx[SW-1:0]] = 1'b1;
                win                = idx[SW-1:0];
            end
        end
    end

    // Select the granted channel's data for the output register.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage and last-winner register; load on accept, drain on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= win;
            last      <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: drives three arbiter configurations (N=4 round-robin,
// N=4 fixed priority, N=3 round-robin) from shared stimulus and compares
// each against a distance-based reference model of the arbitration rules.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vin;
    logic        ordy;
    logic [31:0] din;

    logic [3:0] rdy0, rdy1;
    logic [2:0] rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] od0, od1, od2;
    logic [1:0] os0, os1, os2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per configuration
    bit         ev [3];
    logic [7:0] ed [3];
    int         es [3];
    int         lst[3];
    int         nn [3] = '{4, 4, 3};
    int         md [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .N(4), .MODE(0)) u_rr4 (
        .clk(clk), .reset(rst), .in_valid(vin), .in_data(din), .in_ready(rdy0),
        .out_valid(ov0), .out_ready(ordy), .out_data(od0), .out_sel(os0)
    );

    rr_arb_mux #(.WIDTH(8), .N(4), .MODE(1)) u_fp4 (
        .clk(clk), .reset(rst), .in_valid(vin), .in_data(din), .in_ready(rdy1),
        .out_valid(ov1), .out_ready(ordy), .out_data(od1), .out_sel(os1)
    );

    rr_arb_mux #(.WIDTH(8), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .reset(rst), .in_valid(vin[2:0]), .in_data(din[23:0]), .in_ready(rdy2),
        .out_valid(ov2), .out_ready(ordy), .out_data(od2), .out_sel(os2)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic obs(input int k, output logic [3:0] r, output logic v,
                       output logic [7:0] d, output logic [1:0] s);
        case (k)
            0:       begin r = rdy0;          v = ov0; d = od0; s = os0; end
            1:       begin r = rdy1;          v = ov1; d = od1; s = os1; end
            default: begin r = {1'b0, rdy2}; v = ov2; d = od2; s = os2; end
        endcase
    endtask

    // Winner = requester with the smallest distance from the priority start.
    // Round-robin: distance counted from last+1 modulo n. Fixed: the index itself.
    function automatic int pick(input logic [3:0] v, input int lastv, input int n, input int mode);
        int best  = -1;
        int bestd = 1000;
        int d;
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin
                d = (mode == 1) ? i : (i - lastv - 1 + 2 * n) % n;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ev[k]  = 1'b0;
            ed[k]  = 8'h00;
            es[k]  = 0;
            lst[k] = nn[k] - 1;
        end
    endtask

    task automatic check_cleared(input string tag);
        logic [3:0] r; logic v; logic [7:0] d; logic [1:0] s;
        for (int k = 0; k < 3; k++) begin
            obs(k, r, v, d, s);
            chk($sformatf("%s_valid%0d", tag, k), 32'(v), 32'(0));
            chk($sformatf("%s_data%0d", tag, k), 32'(d), 32'(0));
            chk($sformatf("%s_sel%0d", tag, k), 32'(s), 32'(0));
            chk($sformatf("%s_ready%0d", tag, k), 32'(r), 32'(0));
        end
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input logic [3:0] v, input logic r, input logic [31:0] d);
        int         w[3];
        bit         acc[3];
        logic [3:0] mv;
        logic [3:0] ro; logic vo; logic [7:0] dd; logic [1:0] so;
        vin  = v;
        ordy = r;
        din  = d;
        #1;
        for (int k = 0; k < 3; k++) begin
            mv = '0;
            for (int i = 0; i < nn[k]; i++) mv[i] = v[i];
            w[k]   = pick(mv, lst[k], nn[k], md[k]);
            acc[k] = (!ev[k] || r) && (w[k] >= 0);
            obs(k, ro, vo, dd, so);
            chk($sformatf("in_ready%0d", k), 32'(ro), acc[k] ? (32'(1) << w[k]) : 32'(0));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                ev[k]  = 1'b1;
                ed[k]  = d[w[k]*8 +: 8];
                es[k]  = w[k];
                lst[k] = w[k];
            end else if (r) begin
                ev[k] = 1'b0;
            end
            obs(k, ro, vo, dd, so);
            chk($sformatf("out_valid%0d", k), 32'(vo), 32'(ev[k]));
            if (ev[k]) begin
                chk($sformatf("out_data%0d", k), 32'(dd), 32'(ed[k]));
                chk($sformatf("out_sel%0d", k), 32'(so), 32'(es[k]));
            end
        end
        @(negedge clk);
    endtask

    // Short reset pulse inside the low half of a cycle; called at a negedge.
    task automatic pulse_reset();
        vin = 4'hF;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_cleared("pulse_rst");
        vin = 4'h0;
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), $urandom);
        end
    endtask

    initial begin
        logic [31:0] pat;
        pat  = 32'hA3A2A1A0;
        rst  = 1'b1;
        vin  = '0;
        ordy = 1'b0;
        din  = '0;
        model_reset();
        #2;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // All channels requesting: rotation 0,1,2,3 from the very first edge
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 1'b1, pat);
            chk("rr_seq_sel", 32'(os0), 32'(i % 4));
            chk("rr_seq_data", 32'(od0), 32'(8'hA0 + i % 4));
        end

        // Idle with downstream ready: output drains, priority pointer kept
        for (int i = 0; i < 5; i++) step(4'h0, 1'b1, pat);
        chk("drain_valid", 32'(ov0), 32'(0));

        // Load ch0, stall three cycles, then back-to-back load of ch1
        step(4'hF, 1'b1, pat);
        chk("stall_first_sel", 32'(os0), 32'(0));
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b0, pat);
            chk("stall_hold_data", 32'(od0), 32'(8'hA0));
            chk("stall_ready", 32'(rdy0), 32'(0));
        end
        step(4'hF, 1'b1, pat);
        chk("stall_next_sel", 32'(os0), 32'(1));
        chk("stall_next_data", 32'(od0), 32'(8'hA1));

        random_phase(150);

        // Fixed priority with channels 1 and 3 requesting
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 1'b1, pat);
            chk("fixed_sel", 32'(os1), 32'(1));
        end

        // Three channels, pointer at 2 after reset: 0,2,0,2
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b0101, 1'b1, pat);
            chk("n3_wrap_sel", 32'(os2), (i % 2 == 0) ? 32'(0) : 32'(2));
        end

        // Reset during a stall discards the held beat
        step(4'hF, 1'b0, pat);
        chk("pre_rst_data", 32'(od0), 32'(8'hA2));
        chk("pre_rst_valid", 32'(ov0), 32'(1));
        pulse_reset();
        step(4'b1000, 1'b1, pat);
        chk("post_rst_sel", 32'(os0), 32'(3));
        chk("post_rst_data", 32'(od0), 32'(8'hA3));

        random_phase(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
- REQ-001: Parameter WIDTH, default 64: data width per channel.
- REQ-002: Parameter N, default 4: channel count; legal range 2..16.
- REQ-003: Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: in_valid  input  N  per-channel request; bit i = channel i.
- REQ-007: in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-008: in_ready  output  N  per-channel accept; one-hot or zero.
- REQ-009: out_valid  output  1  output register holds a beat.
- REQ-010: out_ready  input  1  downstream accepts the beat.
- REQ-011: out_data  output  WIDTH  registered selected data.
- REQ-012: out_sel  output  max(1,$clog2(N))  index of the channel that supplied out_data.

Function
- REQ-013: The block SHALL hold one output register stage (out_valid, out_data, out_sel); no combinational path from in_data to out_data.
- REQ-014: can_load = ~out_valid | out_ready; a new beat SHALL load only when can_load and |in_valid.
- REQ-015: grant SHALL be one-hot over requesting channels, zero when in_valid == 0; in_ready = grant & {N{can_load}}.
- REQ-016: MODE 0: winner = first requesting index scanning last+1, last+2, ... with wrap modulo N, where last = most recently accepted index.
- REQ-017: MODE 1: winner = lowest requesting index; last SHALL be ignored.
- REQ-018: last SHALL update to winner only on an accepted transfer (|(in_valid & in_ready)); unchanged otherwise.
- REQ-019: A transfer on channel i SHALL load out_data = in_data[i], out_sel = i, out_valid = 1 on the same edge; latency 1 cycle input-to-output.
- REQ-020: Output handshake SHALL complete when out_valid & out_ready; out_valid falls next edge unless a new beat loads on that edge (back-to-back, full throughput).
- REQ-021: While out_valid & ~out_ready, out_data/out_sel SHALL hold stable and in_ready SHALL be 0.
- REQ-022: Grant SHALL be computed from current in_valid; a channel withdrawing in_valid before transfer loses the grant with no state change.
- REQ-023: Single requester SHALL be granted every cycle regardless of last (wrap-around includes itself).
- REQ-024: N not a power of two SHALL wrap at N-1 -> 0; indices >= N never granted.

Reset
- REQ-025: On reset assertion, immediately and asynchronously: out_valid = 0, out_data = 0, out_sel = 0, last = N-1 (so channel 0 has first priority); in_ready = 0 while reset is high.
- REQ-026: Reset mid-transfer SHALL discard the held beat; no beat from before reset appears afterward.
- REQ-027: First edge after reset release SHALL be able to accept a transfer.

Verification
- REQ-028: N=4, WIDTH=8, MODE 0, in_valid=4'b1111, data ch i = 8'hA0+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, out_data A0..A3 repeating, out_valid=1 from cycle 1 onward.
- REQ-029: MODE 0, out_ready=0 for 3 cycles after first load (ch0, 8'hA0) -> out_data holds 8'hA0, in_ready=4'b0000 for those cycles; on out_ready=1 the next beat loads ch1 same edge.
- REQ-030: MODE 1, in_valid=4'b1010 for 4 cycles, out_ready=1 -> out_sel = 1 every beat; channel 3 never granted.
- REQ-031: N=3, MODE 0, in_valid=3'b101, last=2 at start -> grants 0,2,0,2 (wrap 2->0, index 3 never produced).
- REQ-032: out_valid=1, out_data=8'hA2, reset pulsed for part of a cycle mid-stall -> out_valid=0, out_data=0 immediately; after release with in_valid=4'b1000 the first beat is ch3, 8'hA3.
- REQ-033: in_valid=0 for 5 cycles with out_ready=1 -> in_ready=0, out_valid falls after draining and last unchanged.
